// File: rtl/led_blink_engine.sv
// led_blink_engine: CHANNELS independent LED blink sequencers sharing one
// set of timing inputs. Each channel latches on_len/off_len/reps at start and
// then runs ON/OFF phases on its own private copy.
// Optional feature: define LED_BLINK_DONE_PULSE_EN to get a one-cycle done
// pulse per channel when a counted sequence completes.
module led_blink_engine #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 27,
  parameter int REP_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  input  logic [CNT_W-1:0]    on_len,
  input  logic [CNT_W-1:0]    off_len,
  input  logic [REP_W-1:0]    reps,
  output logic [CHANNELS-1:0] sig,
`ifdef LED_BLINK_DONE_PULSE_EN
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
`else
  output logic [CHANNELS-1:0] busy
`endif
);

  // Start/stop are plain level requests, sampled every cycle; there is no
  // handshake. A start is accepted only in IDLE with stop low; stop always
  // wins and aborts an active sequence on the next edge.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  state_e           state_q [CHANNELS];
  state_e           state_d [CHANNELS];
  logic [CNT_W-1:0] cnt_q   [CHANNELS];
  logic [CNT_W-1:0] cnt_d   [CHANNELS];
  logic [CNT_W-1:0] on_q    [CHANNELS];
  logic [CNT_W-1:0] on_d    [CHANNELS];
  logic [CNT_W-1:0] off_q   [CHANNELS];
  logic [CNT_W-1:0] off_d   [CHANNELS];
  logic [REP_W-1:0] pcnt_q  [CHANNELS];
  logic [REP_W-1:0] pcnt_d  [CHANNELS];
  logic [REP_W-1:0] reps_q  [CHANNELS];
  logic [REP_W-1:0] reps_d  [CHANNELS];
  logic [CHANNELS-1:0] sig_q, sig_d;
  logic [CHANNELS-1:0] busy_q, busy_d;
  logic [CHANNELS-1:0] done_q, done_d;

  // Index of the final cycle of a phase; a zero length behaves as one cycle.
  // Counting 0..len-1 keeps the compare inside CNT_W bits even for all-ones.
  function automatic logic [CNT_W-1:0] last_idx(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  // Per-channel next-state, phase counting and registered output decode.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      on_d[i]    = on_q[i];
      off_d[i]   = off_q[i];
      pcnt_d[i]  = pcnt_q[i];
      reps_d[i]  = reps_q[i];
      done_d[i]  = 1'b0;
      case (state_q[i])
        ST_IDLE: begin
          if (start[i] && !stop[i]) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = '0;
            pcnt_d[i]  = '0;
            on_d[i]    = on_len;
            off_d[i]   = off_len;
            reps_d[i]  = reps;
          end
        end
        ST_ON: begin
          if (stop[i]) begin
            state_d[i] = ST_IDLE;
          end else if (cnt_q[i] == last_idx(on_q[i])) begin
            cnt_d[i] = '0;
            // reps of zero never hits the last-pulse condition: free running.
            if ((reps_q[i] != '0) && (pcnt_q[i] == reps_q[i] - REP_W'(1))) begin
              state_d[i] = ST_IDLE;
              done_d[i]  = 1'b1;
            end else begin
              state_d[i] = ST_OFF;
              pcnt_d[i]  = pcnt_q[i] + REP_W'(1);
            end
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        ST_OFF: begin
          if (stop[i]) begin
            state_d[i] = ST_IDLE;
          end else if (cnt_q[i] == last_idx(off_q[i])) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase
      sig_d[i]  = (state_d[i] == ST_ON);
      busy_d[i] = (state_d[i] != ST_IDLE);
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        on_q[i]    <= '0;
        off_q[i]   <= '0;
        pcnt_q[i]  <= '0;
        reps_q[i]  <= '0;
      end
      sig_q  <= '0;
      busy_q <= '0;
      done_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        on_q[i]    <= on_d[i];
        off_q[i]   <= off_d[i];
        pcnt_q[i]  <= pcnt_d[i];
        reps_q[i]  <= reps_d[i];
      end
      sig_q  <= sig_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign sig  = sig_q;
  assign busy = busy_q;

`ifdef LED_BLINK_DONE_PULSE_EN
  assign done = done_q;
`else
  // Without the done port the pulse register has no load and is trimmed.
  logic unused_done;
  assign unused_done = ^done_q;
`endif

endmodule

// File: tb/tb_led_blink_engine.sv
// Directed self-checking bench for led_blink_engine (CHANNELS=4).
// Inputs change #1 after a rising edge; outputs are sampled at the same point,
// so each tick() moves to the next cycle and shows that edge's results.
module tb_led_blink_engine;

  localparam int CH    = 4;
  localparam int CNT_W = 27;
  localparam int REP_W = 8;

  logic             clk;
  logic             rst;
  logic [CH-1:0]    start;
  logic [CH-1:0]    stop;
  logic [CNT_W-1:0] on_len;
  logic [CNT_W-1:0] off_len;
  logic [REP_W-1:0] reps;
  logic [CH-1:0]    sig;
  logic [CH-1:0]    busy;
`ifdef LED_BLINK_DONE_PULSE_EN
  logic [CH-1:0]    done;
`endif

  int n_checks = 0;
  int n_errors = 0;

  led_blink_engine #(.CHANNELS(CH), .CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .on_len  (on_len),
    .off_len (off_len),
    .reps    (reps),
    .sig     (sig),
`ifdef LED_BLINK_DONE_PULSE_EN
    .busy    (busy),
    .done    (done)
`else
    .busy    (busy)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_gap(input int n);
    start = '0;
    stop  = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic [9:0] e_sig, e_busy, e_done;
    logic [5:0] e6_sig, e6_busy;

    rst = 1'b0; start = '0; stop = '0;
    on_len = '0; off_len = '0; reps = '0;
    tick(); tick();
    check("reset_sig", 32'(sig), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
`ifdef LED_BLINK_DONE_PULSE_EN
    check("reset_done", 32'(done), 32'h0);
`endif
    rst = 1'b1;
    tick();

    // on=3 off=2 reps=2 on ch0; cycles 11..20 relative to start at cycle 10
    on_len = 3; off_len = 2; reps = 2;
    e_sig  = 10'b1110011100;
    e_busy = 10'b1111111100;
    e_done = 10'b0000000010;
    start = 4'b0001;
    tick();
    start = '0;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("basic_sig_c%0d", 11 + k), 32'(sig[0]), 32'(e_sig[9-k]));
      check($sformatf("basic_busy_c%0d", 11 + k), 32'(busy[0]), 32'(e_busy[9-k]));
`ifdef LED_BLINK_DONE_PULSE_EN
      check($sformatf("basic_done_c%0d", 11 + k), 32'(done[0]), 32'(e_done[9-k]));
`endif
      check($sformatf("basic_others_c%0d", 11 + k), 32'(busy[3:1]), 32'h0);
      tick();
    end
    idle_gap(2);

    // zero lengths are one cycle each: 1,0,1,0,1 then idle
    on_len = 0; off_len = 0; reps = 3;
    e6_sig  = 6'b101010;
    e6_busy = 6'b111110;
    start = 4'b0010;
    tick();
    start = '0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("zero_sig_c%0d", k + 1), 32'(sig[1]), 32'(e6_sig[5-k]));
      check($sformatf("zero_busy_c%0d", k + 1), 32'(busy[1]), 32'(e6_busy[5-k]));
      tick();
    end
    idle_gap(2);

    // continuous blink, stop at cycle 20
    on_len = 4; off_len = 4; reps = 0;
    start = 4'b0100;
    tick();
    start = '0;
    for (int k = 1; k <= 20; k++) begin
      check($sformatf("cont_sig_c%0d", k), 32'(sig[2]), (((k - 1) % 8) < 4) ? 32'h1 : 32'h0);
      check($sformatf("cont_busy_c%0d", k), 32'(busy[2]), 32'h1);
      if (k < 20) tick();
    end
    stop = 4'b0100;
    tick();
    stop = '0;
    check("cont_stop_sig", 32'(sig[2]), 32'h0);
    check("cont_stop_busy", 32'(busy[2]), 32'h0);
`ifdef LED_BLINK_DONE_PULSE_EN
    check("cont_stop_done", 32'(done[2]), 32'h0);
`endif
    tick();
    check("cont_stays_idle", 32'(busy[2]), 32'h0);
    idle_gap(2);

    // independent channels: ch0 on=5, ch2 on=2 two cycles later, on_len then changes
    on_len = 5; off_len = 1; reps = 1;
    start = 4'b0001;
    tick();
    for (int k = 1; k <= 7; k++) begin
      check($sformatf("indep_ch0_c%0d", k), 32'(sig[0]), (k <= 5) ? 32'h1 : 32'h0);
      check($sformatf("indep_ch2_c%0d", k), 32'(sig[2]), (k >= 3 && k <= 4) ? 32'h1 : 32'h0);
      check($sformatf("indep_b2_c%0d", k), 32'(busy[2]), (k >= 3 && k <= 4) ? 32'h1 : 32'h0);
      if (k == 1) start = '0;
      if (k == 2) begin start = 4'b0100; on_len = 2; end
      if (k == 3) begin start = '0; on_len = 7; end
      tick();
    end
    idle_gap(2);

    // reset mid ON phase on ch1, with start requests held during reset
    on_len = 4; off_len = 2; reps = 2;
    start = 4'b0010;
    tick();
    start = '0;
    tick();
    check("rstmid_pre_sig", 32'(sig[1]), 32'h1);
    rst = 1'b0;
    start = 4'b1111;
    tick();
    check("rstmid_sig", 32'(sig), 32'h0);
    check("rstmid_busy", 32'(busy), 32'h0);
    tick();
    check("rst_ignores_start", 32'(busy), 32'h0);
    rst = 1'b1;
    start = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rstmid_no_resume_%0d", k), 32'(busy[1]), 32'h0);
    end
    idle_gap(2);

    // start and stop together on idle ch3: stop wins
    start = 4'b1000; stop = 4'b1000;
    tick();
    check("startstop_busy_a", 32'(busy[3]), 32'h0);
    tick();
    check("startstop_busy_b", 32'(busy[3]), 32'h0);

    // start held with reps=1 on=2: ON,ON,idle,ON,ON,idle
    stop = '0; on_len = 2; off_len = 3; reps = 1;
    e6_sig = 6'b110110;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("held_sig_c%0d", k + 1), 32'(sig[3]), 32'(e6_sig[5-k]));
      check($sformatf("held_busy_c%0d", k + 1), 32'(busy[3]), 32'(e6_sig[5-k]));
    end
    idle_gap(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
